// File: rtl/c432_key_loader_if.sv
// Key-loader bus: serial key handshake, load/commit controls, unlock
// confirmation, and the key/status lines that feed the locked c432 core.
`timescale 1ns/1ps
interface c432_key_loader_if #(
  parameter int KEY_W = 19
);
  logic             key_valid;
  logic             key_bit;
  logic             key_ready;
  logic             commit;
  logic             abort;
  logic             relock;
  logic             key_ok;
  logic [KEY_W-1:0] key_out;
  logic             key_active;
  logic             armed;
  logic             lockout;
  logic [4:0]       bit_cnt;
  logic [1:0]       fail_cnt;

  // Key source / supervisor side.
  modport master (
    output key_valid, key_bit, commit, abort, relock, key_ok,
    input  key_ready, key_out, key_active, armed, lockout, bit_cnt, fail_cnt
  );

  // Loader side.
  modport slave (
    input  key_valid, key_bit, commit, abort, relock, key_ok,
    output key_ready, key_out, key_active, armed, lockout, bit_cnt, fail_cnt
  );
endinterface

// File: rtl/c432_key_loader.sv
// Key-load and unlock controller for the logic-locked c432 core.
// Bits shift serially into a shadow register; a commit drives the shadow key
// onto the core and opens a bounded confirmation window. Timeouts restore the
// decoy key and count as failures; MAX_FAIL failures lock the block until rst.
`timescale 1ns/1ps
module c432_key_loader #(
  parameter int               KEY_W      = 19,
  parameter int               VERIFY_CYC = 16,
  parameter int               MAX_FAIL   = 3,
  parameter logic [KEY_W-1:0] DECOY      = 19'h0
) (
  input logic              clk,
  input logic              rst,
  c432_key_loader_if.slave bus
);

  localparam int               TW     = $clog2(VERIFY_CYC + 1);
  localparam logic [4:0]       KEY_WC = 5'(KEY_W);
  localparam logic [TW-1:0]    VCYC   = TW'(VERIFY_CYC);
  localparam logic [TW-1:0]    TONE   = TW'(1);
  localparam logic [1:0]       MAXF   = 2'(MAX_FAIL);
  localparam logic [KEY_W-1:0] ZKEY   = {KEY_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    FULL    = 3'd2,
    VERIFY  = 3'd3,
    ARMED   = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  state_t           state_r,      state_s;
  logic [KEY_W-1:0] shadow_r,     shadow_s;
  logic [KEY_W-1:0] key_out_r,    key_out_s;
  logic [4:0]       bit_cnt_r,    bit_cnt_s;
  logic [1:0]       fail_cnt_r,   fail_cnt_s;
  logic [TW-1:0]    timer_r,      timer_s;
  logic             key_active_r, key_active_s;
  logic             armed_r,      armed_s;
  logic             lockout_r,    lockout_s;
  logic             key_ready_r,  key_ready_s;
  logic             accept_s;

  // State and output registers; async reset returns to IDLE with the decoy key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      shadow_r     <= ZKEY;
      key_out_r    <= DECOY;
      bit_cnt_r    <= 5'd0;
      fail_cnt_r   <= 2'd0;
      timer_r      <= {TW{1'b0}};
      key_active_r <= 1'b0;
      armed_r      <= 1'b0;
      lockout_r    <= 1'b0;
      key_ready_r  <= 1'b1;
    end else begin
      state_r      <= state_s;
      shadow_r     <= shadow_s;
      key_out_r    <= key_out_s;
      bit_cnt_r    <= bit_cnt_s;
      fail_cnt_r   <= fail_cnt_s;
      timer_r      <= timer_s;
      key_active_r <= key_active_s;
      armed_r      <= armed_s;
      lockout_r    <= lockout_s;
      key_ready_r  <= key_ready_s;
    end
  end

  // Next-state and next-output logic; abort outranks a bit or a commit.
  always_comb begin
    state_s      = state_r;
    shadow_s     = shadow_r;
    key_out_s    = key_out_r;
    bit_cnt_s    = bit_cnt_r;
    fail_cnt_s   = fail_cnt_r;
    timer_s      = timer_r;
    key_active_s = key_active_r;
    armed_s      = armed_r;
    lockout_s    = lockout_r;
    accept_s     = bus.key_valid && key_ready_r && !bus.abort;

    case (state_r)
      IDLE, SHIFT: begin
        if (bus.abort) begin
          state_s   = IDLE;
          shadow_s  = ZKEY;
          bit_cnt_s = 5'd0;
        end else if (accept_s) begin
          shadow_s  = {bus.key_bit, shadow_r[KEY_W-1:1]};
          bit_cnt_s = bit_cnt_r + 5'd1;
          if (bit_cnt_s == KEY_WC) begin
            state_s = FULL;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = state_r;
        end
      end

      FULL: begin
        if (bus.abort) begin
          state_s   = IDLE;
          shadow_s  = ZKEY;
          bit_cnt_s = 5'd0;
        end else if (bus.commit) begin
          key_out_s    = shadow_r;
          key_active_s = 1'b1;
          timer_s      = VCYC;
          state_s      = VERIFY;
        end else begin
          state_s = FULL;
        end
      end

      VERIFY: begin
        if (bus.key_ok) begin
          armed_s = 1'b1;
          timer_s = {TW{1'b0}};
          state_s = ARMED;
        end else if (timer_r == TONE) begin
          // Last window cycle without confirmation: the attempt fails.
          timer_s      = {TW{1'b0}};
          key_out_s    = DECOY;
          key_active_s = 1'b0;
          shadow_s     = ZKEY;
          bit_cnt_s    = 5'd0;
          fail_cnt_s   = fail_cnt_r + 2'd1;
          if (fail_cnt_s == MAXF) begin
            lockout_s = 1'b1;
            state_s   = LOCKOUT;
          end else begin
            state_s = IDLE;
          end
        end else begin
          timer_s = timer_r - TONE;
        end
      end

      ARMED: begin
        if (bus.relock) begin
          key_out_s    = DECOY;
          key_active_s = 1'b0;
          armed_s      = 1'b0;
          shadow_s     = ZKEY;
          bit_cnt_s    = 5'd0;
          state_s      = IDLE;
        end else begin
          state_s = ARMED;
        end
      end

      LOCKOUT: begin
        state_s = LOCKOUT;
      end

      default: begin
        state_s      = IDLE;
        shadow_s     = ZKEY;
        key_out_s    = DECOY;
        bit_cnt_s    = 5'd0;
        timer_s      = {TW{1'b0}};
        key_active_s = 1'b0;
        armed_s      = 1'b0;
      end
    endcase

    key_ready_s = (state_s == IDLE) || (state_s == SHIFT);
  end

  assign bus.key_ready  = key_ready_r;
  assign bus.key_out    = key_out_r;
  assign bus.key_active = key_active_r;
  assign bus.armed      = armed_r;
  assign bus.lockout    = lockout_r;
  assign bus.bit_cnt    = bit_cnt_r;
  assign bus.fail_cnt   = fail_cnt_r;

endmodule

// File: tb/tb_c432_key_loader.sv
// Self-checking bench for c432_key_loader: directed scenarios followed by a
// randomized run, all checked each cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_c432_key_loader;
  localparam int KEY_W      = 19;
  localparam int VERIFY_CYC = 16;
  localparam int MAX_FAIL   = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  c432_key_loader_if #(.KEY_W(KEY_W)) bus ();

  c432_key_loader #(
    .KEY_W(KEY_W), .VERIFY_CYC(VERIFY_CYC), .MAX_FAIL(MAX_FAIL), .DECOY(19'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: bits loaded so far, window cycles left, flags.
  logic        m_bits[$];
  int          m_win;
  int          m_fails;
  bit          m_armed, m_locked, m_active;
  logic [18:0] m_kout;

  function automatic logic [18:0] packed_key();
    logic [18:0] v;
    v = 19'h0;
    for (int i = 0; i < m_bits.size(); i++) v[i] = m_bits[i];
    return v;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_win = 0; m_fails = 0;
    m_armed = 1'b0; m_locked = 1'b0; m_active = 1'b0;
    m_kout = 19'h0;
  endtask

  task automatic model_step();
    if (m_locked) begin
      // everything ignored
    end else if (m_armed) begin
      if (bus.relock) begin
        m_armed = 1'b0; m_active = 1'b0; m_kout = 19'h0; m_bits.delete();
      end
    end else if (m_win > 0) begin
      if (bus.key_ok) begin
        m_armed = 1'b1; m_win = 0;
      end else begin
        m_win--;
        if (m_win == 0) begin
          m_kout = 19'h0; m_active = 1'b0; m_bits.delete(); m_fails++;
          if (m_fails == MAX_FAIL) m_locked = 1'b1;
        end
      end
    end else if (bus.abort) begin
      m_bits.delete();
    end else if (m_bits.size() == KEY_W) begin
      if (bus.commit) begin
        m_kout = packed_key(); m_active = 1'b1; m_win = VERIFY_CYC;
      end
    end else if (bus.key_valid) begin
      m_bits.push_back(bus.key_bit);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_ready;
    exp_ready = !m_locked && !m_armed && (m_win == 0) && (m_bits.size() < KEY_W);
    chk("key_ready",  {31'h0, bus.key_ready},  {31'h0, exp_ready});
    chk("bit_cnt",    {27'h0, bus.bit_cnt},    32'(m_bits.size()));
    chk("key_out",    {13'h0, bus.key_out},    {13'h0, m_kout});
    chk("key_active", {31'h0, bus.key_active}, {31'h0, m_active});
    chk("armed",      {31'h0, bus.armed},      {31'h0, m_armed});
    chk("lockout",    {31'h0, bus.lockout},    {31'h0, m_locked});
    chk("fail_cnt",   {30'h0, bus.fail_cnt},   32'(m_fails));
  endtask

  task automatic set_in(input logic v, input logic b, input logic c,
                        input logic a, input logic r, input logic ok);
    bus.key_valid = v; bus.key_bit = b; bus.commit = c;
    bus.abort = a; bus.relock = r; bus.key_ok = ok;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: model consumes the held inputs, DUT samples them, then compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic load_key(input logic [18:0] k);
    for (int i = 0; i < KEY_W; i++) begin
      set_in(1'b1, k[i], 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle_in();
  endtask

  task automatic commit_tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in();
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [18:0] k;
    idle_in();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_key_out", {13'h0, bus.key_out}, 32'h0);
    chk("rst_ready", {31'h0, bus.key_ready}, 32'h1);
    rst = 1'b0;

    // Reset in the middle of a load.
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("midload_cnt", {27'h0, bus.bit_cnt}, 32'd10);
    idle_in();
    apply_reset();
    chk("midrst_cnt", {27'h0, bus.bit_cnt}, 32'd0);
    chk("midrst_ready", {31'h0, bus.key_ready}, 32'h1);

    // Successful unlock with key_ok three cycles after commit.
    load_key(19'h5A5A5);
    chk("full_cnt", {27'h0, bus.bit_cnt}, 32'd19);
    commit_tick();
    chk("commit_key", {13'h0, bus.key_out}, 32'h5A5A5);
    tick();
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("unlock_armed", {31'h0, bus.armed}, 32'h1);
    idle_in();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("armed_hold", {13'h0, bus.key_out}, 32'h5A5A5);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle_in();
    chk("relock_key", {13'h0, bus.key_out}, 32'h0);
    chk("relock_fail", {30'h0, bus.fail_cnt}, 32'h0);

    // Early commit ignored; abort beats a simultaneous bit.
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    commit_tick();
    chk("early_commit", {31'h0, bus.key_active}, 32'h0);
    chk("early_cnt", {27'h0, bus.bit_cnt}, 32'd12);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_in();
    chk("abort_cnt", {27'h0, bus.bit_cnt}, 32'd0);
    k = 19'($urandom);
    load_key(k);
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle_in();
    chk("abort_commit", {31'h0, bus.key_active}, 32'h0);

    // key_ok only on the last window cycle still unlocks.
    k = 19'($urandom);
    load_key(k);
    commit_tick();
    repeat (VERIFY_CYC - 1) tick();
    chk("win_active", {31'h0, bus.key_active}, 32'h1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("win_armed", {31'h0, bus.armed}, 32'h1);
    chk("win_fail", {30'h0, bus.fail_cnt}, 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle_in();

    // Three timeouts, reloading on the first cycle back in IDLE.
    for (int n = 1; n <= MAX_FAIL; n++) begin
      k = 19'($urandom);
      load_key(k);
      commit_tick();
      chk("to_key", {13'h0, bus.key_out}, {13'h0, k});
      repeat (VERIFY_CYC - 1) tick();
      chk("to_pre", {31'h0, bus.key_active}, 32'h1);
      tick();
      chk("to_active", {31'h0, bus.key_active}, 32'h0);
      chk("to_key_decoy", {13'h0, bus.key_out}, 32'h0);
      chk("to_fail", {30'h0, bus.fail_cnt}, 32'(n));
    end
    chk("lock_flag", {31'h0, bus.lockout}, 32'h1);
    for (int i = 0; i < 30; i++) begin
      set_in(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
             1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      tick();
    end
    idle_in();
    chk("lock_ready", {31'h0, bus.key_ready}, 32'h0);
    chk("lock_fail", {30'h0, bus.fail_cnt}, 32'd3);
    apply_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      set_in($urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(3) == 0,
             $urandom_range(31) == 0, $urandom_range(15) == 0, $urandom_range(23) == 0);
      tick();
    end
    idle_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/c432_key_loader.md
# c432_key_loader

Sequential key-load and unlock controller for the logic-locked c432 core. Key bits arrive serially over a valid/ready handshake into a shadow register. On commit the key is applied to the core's key inputs (p1..p4, X_1..X_15) and the block waits a bounded window for an external unlock confirmation. Failed attempts restore a decoy key and are counted; too many failures put the block in a terminal lockout until reset.

## Interface
- KEY_W, 19, key width: 4 mux-select bits plus 15 XOR bits
- VERIFY_CYC, 16, length of the confirmation window in cycles (≥1)
- MAX_FAIL, 3, failed attempts that trigger lockout (≥1)
- DECOY, 19'h0, key value driven whenever no committed key is active

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- key_valid  in  1  key_bit is valid this cycle
- key_bit  in  1  serial key bit
- key_ready  out  1  loader accepts a bit this cycle
- commit  in  1  apply the shadow key (honoured only in FULL)
- abort  in  1  discard a partial or full shadow key
- relock  in  1  leave ARMED and restore DECOY
- key_ok  in  1  unlock confirmation from the checker
- key_out  out  KEY_W  to core: [0]=p1 … [3]=p4, [4]=X_1 … [18]=X_15
- key_active  out  1  key_out holds a committed key
- armed  out  1  unlock confirmed
- lockout  out  1  terminal lockout
- bit_cnt  out  5  bits accepted in the current load, 0..KEY_W
- fail_cnt  out  2  failed attempts, saturates at MAX_FAIL

## Operation
- States: IDLE, SHIFT, FULL, VERIFY, ARMED, LOCKOUT.
- Reset (async, any state): state=IDLE, shadow=0, key_out=DECOY, bit_cnt=0, fail_cnt=0, timer=0. All status outputs are 0.
- key_ready = 1 in IDLE and SHIFT; 0 in every other state.
- Bit acceptance: a bit is accepted when key_valid && key_ready && !abort.
  - shadow <= {key_bit, shadow[KEY_W-1:1]}, and bit_cnt increments.
  - The first bit accepted ends in shadow[0]; the last bit accepted ends in shadow[KEY_W-1].
- Load transitions:
  - IDLE → SHIFT on the first accepted bit.
  - SHIFT → FULL on the accept that makes bit_cnt=KEY_W.
- abort in IDLE, SHIFT or FULL: go to IDLE and clear shadow and bit_cnt. abort wins over a simultaneous bit or commit. abort is ignored in VERIFY, ARMED and LOCKOUT.
- commit outside FULL is ignored.
- commit in FULL:
  - key_out <= shadow and key_active <= 1.
  - timer <= VERIFY_CYC, then go to VERIFY.
- VERIFY, evaluated each cycle:
  - key_ok=1 → ARMED (armed=1, key held). key_ok takes priority on the final window cycle.
  - Otherwise the timer decrements. On the cycle the timer reaches 0 without key_ok, the attempt fails:
    - key_out <= DECOY, key_active <= 0, fail_cnt++, and shadow and bit_cnt are cleared.
    - If the new fail_cnt equals MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
- ARMED: key_out is held. relock → IDLE with key_out=DECOY, key_active=0, armed=0, shadow and bit_cnt cleared, fail_cnt unchanged.
- LOCKOUT: lockout=1 and key_out=DECOY. Every input is ignored; only rst exits this state.
- A successful unlock does not reset fail_cnt; only rst clears it.

## Timing
- All outputs are registered, and every change appears on the clock edge after the qualifying input cycle.
- Load and commit:
  - A full load takes KEY_W accepted cycles; back-to-back bits are allowed.
  - key_out changes one cycle after commit is sampled in FULL.
- Verify window:
  - key_ok is sampled on exactly VERIFY_CYC cycles, counted from the first cycle in VERIFY.
  - On a timeout, DECOY is restored on the edge ending the last window cycle.
- key_ok outside VERIFY has no effect.
- A new load is accepted on the first cycle back in IDLE.

## Test plan
- Reset mid-load: accept 10 bits, assert rst → bit_cnt=0, key_out=19'h0, state IDLE, key_ready=1.
- Successful unlock:
  - Stimulus: shift 19 bits with key_valid held; the resulting shadow equals 19'h5A5A5; commit; key_ok pulsed 3 cycles later.
  - Required: key_out=19'h5A5A5 one cycle after commit, then armed=1.
  - relock afterwards → key_out=19'h0, fail_cnt=0.
- Timeout: full load, commit, key_ok never asserted → key_out returns to DECOY exactly 16 cycles after VERIFY entry, fail_cnt=1, state IDLE.
- Lockout: three consecutive timeouts → lockout=1 and fail_cnt=3. Further bits, commit and key_ok have no effect; key_ready=0 until rst.
- Abort and early-commit priority:
  - commit after 12 bits → ignored.
  - abort together with key_valid on bit 13 → bit_cnt=0, bit not stored.
- Window boundary: key_ok asserted only on the 16th window cycle → ARMED, and fail_cnt is unchanged.
